// File: rtl/wdata_burst_buf_if.sv
// Bundle of the upstream beat port, the burst commit handshake and the AXI4 W channel
// for wdata_burst_buf. master = upstream/address-generator/W-slave side, slave = buffer.
interface wdata_burst_buf_if #(
  parameter int DSIZE = 256
);
  logic                 iwr_en;
  logic                 ilast_en;
  logic [DSIZE-1:0]     idata;
  logic [DSIZE/8-1:0]   imask;
  logic                 ofull;
  logic                 oerr;
  logic                 oburst_req;
  logic [7:0]           oburst_len;
  logic                 iburst_ack;
  logic                 axi_wvalid;
  logic                 axi_wready;
  logic [DSIZE-1:0]     axi_wdata;
  logic [DSIZE/8-1:0]   axi_wstrb;
  logic                 axi_wlast;

  modport master (
    output iwr_en, ilast_en, idata, imask, iburst_ack, axi_wready,
    input  ofull, oerr, oburst_req, oburst_len, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast
  );

  modport slave (
    input  iwr_en, ilast_en, idata, imask, iburst_ack, axi_wready,
    output ofull, oerr, oburst_req, oburst_len, axi_wvalid, axi_wdata, axi_wstrb, axi_wlast
  );
endinterface

// File: rtl/wdata_burst_buf.sv
// Write-data burst buffer: beat FIFO that offers bursts to an address generator and streams them on AXI4 W.
// Define WDATA_BURST_BUF_STRB_EN to store the byte mask and drive it onto axi_wstrb (else all ones).
module wdata_burst_buf #(
  parameter int DSIZE     = 256,
  parameter int DEPTH     = 32,
  parameter int BURST_LEN = 16
) (
  input logic              clock,
  input logic              rst_n,
  wdata_burst_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;
  state_t state, state_nxt;

  logic [DSIZE-1:0] data_mem [DEPTH];
  logic             last_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr, last_ptr, count, last_dist;
  logic          pend_last, oerr_q;
  logic [7:0]    beat_cnt, burst_len, len_nxt;
  logic          full, wr, rd, wvalid, last_rd;

  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == PW'(DEPTH));
  assign wr        = bus.iwr_en && !full;
  assign wvalid    = (state == DATA) && (count != '0);
  assign rd        = wvalid && bus.axi_wready;
  assign last_dist = last_ptr - rd_ptr;
  assign last_rd   = rd && pend_last && (rd_ptr == last_ptr) && last_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr) begin
      data_mem[wr_ptr[AW-1:0]] <= bus.idata;
      last_mem[wr_ptr[AW-1:0]] <= bus.ilast_en;
    end
  end

`ifdef WDATA_BURST_BUF_STRB_EN
  logic [DSIZE/8-1:0] mask_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr) mask_mem[wr_ptr[AW-1:0]] <= bus.imask;
  end

  assign bus.axi_wstrb = mask_mem[rd_ptr[AW-1:0]];
`else
  assign bus.axi_wstrb = '1;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_ptr  <= '0;
      pend_last <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + PW'(1);
      if (rd) rd_ptr <= rd_ptr + PW'(1);
      // A second last while one is pending is flagged and not tracked.
      if (wr && bus.ilast_en && !pend_last) begin
        last_ptr  <= wr_ptr;
        pend_last <= 1'b1;
      end else if (last_rd) begin
        pend_last <= 1'b0;
      end
      if ((bus.iwr_en && full) || (wr && bus.ilast_en && pend_last)) oerr_q <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      burst_len <= '0;
      beat_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      burst_len <= len_nxt;
      if (state != DATA) beat_cnt <= '0;
      else if (rd)       beat_cnt <= (beat_cnt == burst_len) ? '0 : beat_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = burst_len;
    unique case (state)
      IDLE: begin
        // A pending line end caps the burst so it never spans past the last beat.
        if (pend_last) begin
          state_nxt = REQ;
          len_nxt   = (last_dist >= PW'(BURST_LEN)) ? 8'(BURST_LEN - 1) : 8'(last_dist);
        end else if (count >= PW'(BURST_LEN)) begin
          state_nxt = REQ;
          len_nxt   = 8'(BURST_LEN - 1);
        end
      end
      REQ:     if (bus.iburst_ack) state_nxt = DATA;
      DATA:    if (rd && (beat_cnt == burst_len)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ofull      = full;
  assign bus.oerr       = oerr_q;
  assign bus.oburst_req = (state == REQ);
  assign bus.oburst_len = burst_len;
  assign bus.axi_wvalid = wvalid;
  assign bus.axi_wdata  = data_mem[rd_ptr[AW-1:0]];
  assign bus.axi_wlast  = wvalid && (beat_cnt == burst_len);
endmodule

// File: tb/tb_wdata_burst_buf.sv
// Directed bench for wdata_burst_buf: table-driven short burst plus hand-written
// long-burst, overflow, strobe and mid-burst reset sequences.
module tb_wdata_burst_buf;
  localparam int DSIZE     = 256;
  localparam int DEPTH     = 32;
  localparam int BURST_LEN = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wdata_burst_buf_if #(.DSIZE(DSIZE)) bus ();

  wdata_burst_buf #(.DSIZE(DSIZE), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int wr, last, ack, rdy, d;
    int e_req, e_len, e_valid, e_wlast, e_data;
  } vec_t;
  vec_t tbl[15];

  function automatic logic [255:0] dat(input int v);
    return {8{32'(v)}};
  endfunction

  function automatic logic [31:0] strb_exp(input logic [31:0] m);
`ifdef WDATA_BURST_BUF_STRB_EN
    return m;
`else
    return (m | ~m);
`endif
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.iwr_en     = 1'b0;
    bus.ilast_en   = 1'b0;
    bus.idata      = '0;
    bus.imask      = '1;
    bus.iburst_ack = 1'b0;
    bus.axi_wready = 1'b0;
  endtask

  task automatic write_beat(input int v, input logic last, input logic [31:0] mask);
    bus.iwr_en   = 1'b1;
    bus.ilast_en = last;
    bus.idata    = dat(v);
    bus.imask    = mask;
    step();
    bus.iwr_en   = 1'b0;
    bus.ilast_en = 1'b0;
    bus.imask    = '1;
  endtask

  task automatic wait_req(input int exp_len);
    for (int i = 0; i < 60 && !bus.oburst_req; i++) step();
    check("burst_req", 256'(bus.oburst_req), 256'(1));
    check("burst_len", 256'(bus.oburst_len), 256'(exp_len));
    bus.iburst_ack = 1'b1;
    step();
    bus.iburst_ack = 1'b0;
  endtask

  // Offer/ack one burst, then collect its beats and compare against base+index.
  task automatic drain(input int exp_len, input int base, input bit stall,
                       input logic [31:0] last_strb, input bit collide);
    int idx;
    bit prev_stall;
    logic [255:0] prev_data;
    logic prev_last;
    idx = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_last = 1'b0;
    wait_req(exp_len);
    for (int cyc = 0; cyc < 200 && idx <= exp_len; cyc++) begin
      bus.axi_wready = (stall && !(collide && cyc == 0)) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (collide && cyc == 0) begin
        check("full_before_collide", 256'(bus.ofull), 256'(1));
        bus.iwr_en = 1'b1;
        bus.idata  = dat(777);
      end
      if (prev_stall) begin
        check("stall_wvalid", 256'(bus.axi_wvalid), 256'(1));
        check("stall_wdata", bus.axi_wdata, prev_data);
        check("stall_wlast", 256'(bus.axi_wlast), 256'(prev_last));
      end
      if (bus.axi_wvalid && bus.axi_wready) begin
        check("beat_data", bus.axi_wdata, dat(base + idx));
        check("beat_wlast", 256'(bus.axi_wlast), 256'(idx == exp_len));
        check("beat_strb", 256'(bus.axi_wstrb), 256'((idx == exp_len) ? last_strb : strb_exp(32'hFFFF_FFFF)));
        idx++;
      end
      prev_stall = bus.axi_wvalid && !bus.axi_wready;
      prev_data  = bus.axi_wdata;
      prev_last  = bus.axi_wlast;
      step();
      bus.iwr_en = 1'b0;
    end
    bus.axi_wready = 1'b0;
    check("burst_beats", 256'(idx), 256'(exp_len + 1));
    check("post_burst_wvalid", 256'(bus.axi_wvalid), 256'(0));
    check("post_burst_req", 256'(bus.oburst_req), 256'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_ofull", 256'(bus.ofull), 256'(0));
    check("rst_oerr", 256'(bus.oerr), 256'(0));
    check("rst_req", 256'(bus.oburst_req), 256'(0));
    check("rst_len", 256'(bus.oburst_len), 256'(0));
    check("rst_wvalid", 256'(bus.axi_wvalid), 256'(0));
    check("rst_wlast", 256'(bus.axi_wlast), 256'(0));
    rst_n = 1'b1;
    step();

    // Five-beat line with last on beat 4, one stall, ack ignored once idle again.
    //            wr last ack rdy d   req len val wlast data
    tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 0, 2,  0, 0, 0, 0, 0};
    tbl[3]  = '{1, 0, 0, 0, 3,  0, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 0, 0, 4,  0, 0, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 1, 1, 0,  1, 4, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 0};
    tbl[8]  = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0,  0, 0, 1, 0, 2};
    tbl[10] = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 2};
    tbl[11] = '{0, 0, 0, 1, 0,  0, 0, 1, 0, 3};
    tbl[12] = '{0, 0, 0, 1, 0,  0, 0, 1, 1, 4};
    tbl[13] = '{0, 0, 1, 0, 0,  0, 0, 0, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
    for (int i = 0; i < 15; i++) begin
      bus.iwr_en     = 1'(tbl[i].wr);
      bus.ilast_en   = 1'(tbl[i].last);
      bus.idata      = dat(tbl[i].d);
      bus.iburst_ack = 1'(tbl[i].ack);
      bus.axi_wready = 1'(tbl[i].rdy);
      check($sformatf("tbl%0d_req", i), 256'(bus.oburst_req), 256'(tbl[i].e_req));
      check($sformatf("tbl%0d_wvalid", i), 256'(bus.axi_wvalid), 256'(tbl[i].e_valid));
      check($sformatf("tbl%0d_wlast", i), 256'(bus.axi_wlast), 256'(tbl[i].e_wlast));
      if (tbl[i].e_req != 0)
        check($sformatf("tbl%0d_len", i), 256'(bus.oburst_len), 256'(tbl[i].e_len));
      if (tbl[i].e_valid != 0)
        check($sformatf("tbl%0d_wdata", i), bus.axi_wdata, dat(tbl[i].e_data));
      step();
    end
    clear_inputs();

    // Full-length burst with random wready stalls.
    for (int i = 0; i < 16; i++) write_beat(100 + i, 1'b0, 32'hFFFF_FFFF);
    drain(15, 100, 1'b1, strb_exp(32'hFFFF_FFFF), 1'b0);

    // Fill to depth, overflow, then read+write while full.
    for (int i = 0; i < 32; i++) write_beat(200 + i, 1'b0, 32'hFFFF_FFFF);
    check("full_at_depth", 256'(bus.ofull), 256'(1));
    check("no_err_before_overflow", 256'(bus.oerr), 256'(0));
    write_beat(999, 1'b0, 32'hFFFF_FFFF);
    check("err_on_overflow", 256'(bus.oerr), 256'(1));
    check("full_after_drop", 256'(bus.ofull), 256'(1));
    drain(15, 200, 1'b0, strb_exp(32'hFFFF_FFFF), 1'b1);
    check("full_cleared", 256'(bus.ofull), 256'(0));
    drain(15, 216, 1'b0, strb_exp(32'hFFFF_FFFF), 1'b0);
    // Single-beat line: length 0 proves the colliding write was dropped.
    write_beat(500, 1'b1, 32'h0000_FFFF);
    drain(0, 500, 1'b0, strb_exp(32'h0000_FFFF), 1'b0);
    check("err_sticky", 256'(bus.oerr), 256'(1));

    // Reset in the middle of a burst.
    for (int i = 0; i < 16; i++) write_beat(300 + i, 1'b0, 32'hFFFF_FFFF);
    wait_req(15);
    bus.axi_wready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("pre_reset_beat", bus.axi_wdata, dat(300 + i));
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wvalid", 256'(bus.axi_wvalid), 256'(0));
    check("midrst_wlast", 256'(bus.axi_wlast), 256'(0));
    check("midrst_req", 256'(bus.oburst_req), 256'(0));
    check("midrst_len", 256'(bus.oburst_len), 256'(0));
    check("midrst_ofull", 256'(bus.ofull), 256'(0));
    check("midrst_oerr", 256'(bus.oerr), 256'(0));
    bus.axi_wready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    write_beat(400, 1'b0, 32'hFFFF_FFFF);
    write_beat(401, 1'b0, 32'hFFFF_FFFF);
    write_beat(402, 1'b1, 32'hFFFF_FFFF);
    drain(2, 400, 1'b0, strb_exp(32'hFFFF_FFFF), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
